// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions for the load/store path:
//   - XLEN data/address width
//   - funct3 width/sign codes for loads and stores
//   - load_store_unit FSM state encoding
//   - small helpers to classify a funct3/address pair
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] LSU_IDLE      = 2'd0;
    localparam logic [1:0] LSU_LD_DATA   = 2'd1;
    localparam logic [1:0] LSU_RMW_MERGE = 2'd2;

    // Stores only exist in B/H/W form; loads add the unsigned B/H variants.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // funct3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b10) && (lo != 2'b00)) ||
               ((f3[1:0] == 2'b01) && lo[0]);
    endfunction

    function automatic logic [1:0] f3_force_align(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b10:   return 2'b00;
            2'b01:   return {lo[1], 1'b0};
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane logic shared by the load and read-modify-write paths.
// Ports:
//   i_funct3     in  3   width/sign code of the captured request
//   i_offset     in  2   byte offset within the word (already aligned as needed)
//   i_rdata      in  32  word read from memory
//   i_wdata      in  16  low store data bytes (SB uses [7:0], SH uses [15:0])
//   o_load_data  out 32  selected lane, sign/zero extended
//   o_merge_data out 32  i_rdata with the store lane replaced
// ---------------------------------------------------------------------------
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [15:0]     i_wdata,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Little-endian lane pick: byte k lives at [8k+7:8k], half selected by offset[1].
    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    always_comb begin
        o_merge_data = i_rdata;
        if (i_funct3 == F3_B) begin
            case (i_offset)
                2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
                2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
                2'd2:    o_merge_data[23:16] = i_wdata[7:0];
                default: o_merge_data[31:24] = i_wdata[7:0];
            endcase
        end else if (i_funct3 == F3_H) begin
            if (i_offset[1])
                o_merge_data[31:16] = i_wdata;
            else
                o_merge_data[15:0]  = i_wdata;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// MEM-stage initiator for a single-port word memory (1-cycle sync read, word
// write, read-before-write). Handles RV32I loads with lane extract/extend and
// sub-word stores by read-modify-write. One request in flight.
// Configuration macro: MISALIGN_TRAP_EN
//   defined   -> misaligned word/half accesses are rejected with resp_err
//   undefined -> offending low address bits are forced to zero
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_is_store, req_funct3    operation and width/sign code
//   req_addr, req_wdata         byte address, store data
//   resp_valid/rdata/err        1-cycle response pulse
//   mem_write_en/addr/write_data  memory request (addr is a word index)
//   mem_read_data               memory word, valid one cycle after mem_addr
// ---------------------------------------------------------------------------
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_write_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_write_data,
    input  logic [XLEN-1:0] mem_read_data
);

    logic [1:0]        r_state;
    logic [2:0]        r_funct3;
    logic [MEM_AW+1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [XLEN-1:0]   r_resp_rdata;

    logic              w_accept;
    logic              w_reject;
    logic              w_go;
    logic              w_is_sw;
    logic              w_misaligned;
    logic [1:0]        w_addr_lo;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN-1:0]   w_merge_data;
    logic              w_unused_addr;

    assign w_unused_addr = ^req_addr[XLEN-1:MEM_AW+2];

    assign req_ready = (r_state == LSU_IDLE);
    assign w_accept  = req_ready && req_valid;
    assign w_is_sw   = req_is_store && (req_funct3 == F3_W);

`ifdef MISALIGN_TRAP_EN
    assign w_misaligned = f3_misaligned(req_funct3, req_addr[1:0]);
    assign w_addr_lo    = req_addr[1:0];
`else
    assign w_misaligned = 1'b0;
    assign w_addr_lo    = f3_force_align(req_funct3, req_addr[1:0]);
`endif

    assign w_reject = !f3_legal(req_is_store, req_funct3) || w_misaligned;
    assign w_go     = w_accept && !w_reject;

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_offset     (r_addr[1:0]),
        .i_rdata      (mem_read_data),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Memory side: the accept cycle drives the request address straight from
    // the pipeline so the read data lands in the following cycle; a rejected
    // request never touches memory. RMW_MERGE writes back the merged word.
    always_comb begin
        mem_write_en   = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (r_state)
            LSU_IDLE: begin
                if (w_go) begin
                    mem_addr = {{(XLEN-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
                    if (w_is_sw) begin
                        mem_write_en   = 1'b1;
                        mem_write_data = req_wdata;
                    end
                end
            end
            LSU_LD_DATA: begin
                mem_addr = {{(XLEN-MEM_AW){1'b0}}, r_addr[MEM_AW+1:2]};
            end
            LSU_RMW_MERGE: begin
                mem_write_en   = 1'b1;
                mem_addr       = {{(XLEN-MEM_AW){1'b0}}, r_addr[MEM_AW+1:2]};
                mem_write_data = w_merge_data;
            end
            default: ;
        endcase
    end

    // FSM and response registers. Responses are single-cycle pulses; SW and
    // rejected requests answer one cycle after accept without leaving IDLE,
    // which lets back-to-back SW stream at one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LSU_IDLE;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= req_funct3;
                        r_addr   <= {req_addr[MEM_AW+1:2], w_addr_lo};
                        r_wdata  <= req_wdata[15:0];
                        if (w_reject) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (w_is_sw) begin
                            r_resp_valid <= 1'b1;
                        end else if (req_is_store) begin
                            r_state <= LSU_RMW_MERGE;
                        end else begin
                            r_state <= LSU_LD_DATA;
                        end
                    end
                end
                LSU_LD_DATA: begin
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                    r_state      <= LSU_IDLE;
                end
                LSU_RMW_MERGE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= LSU_IDLE;
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
